rr_bit_arbiter: RTL and testbench

//   Round-robin arbiter that shares one registered single-bit output channel

---
 rtl/rr_arb_pkg.sv | 35 +++
 rtl/rr_prio_pick.sv | 36 +++
 rtl/rr_bit_arbiter.sv | 130 +++++++++++++
 tb/tb_rr_bit_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and a behavioural round-robin pick used to cross-check the
// structural picker in simulation.
package rr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int unsigned RR_MAX_REQ = 32;
  localparam int unsigned RR_IDX_W   = 5;

  typedef struct packed {
    logic                valid;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // First set request scanning ptr, ptr+1, ... modulo n.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX_REQ-1:0] req,
                                       input int unsigned          ptr,
                                       input int unsigned          n);
    rr_pick_t    res;
    int unsigned cand;
    res = '0;
    for (int unsigned k = 0; k < n; k++) begin
      cand = (ptr + k) % n;
      if (!res.valid && req[cand[RR_IDX_W-1:0]]) begin
        res.valid = 1'b1;
        res.idx   = cand[RR_IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational round-robin picker: rotate requests so ptr sits at bit 0,
// priority-encode the lowest set bit, then rotate the index back.
module rr_prio_pick #(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [2*N_REQ-1:0] doubled;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W-1:0]   off;
  logic [IDX_W:0]     sum;

  always_comb begin
    doubled = {req, req} >> ptr;
    rot     = doubled[N_REQ-1:0];
    valid   = |rot;
    off     = '0;
    // Scan downwards so the lowest set bit is the one left in off.
    for (int unsigned k = N_REQ; k > 0; k--) begin
      if (rot[IDX_W'(k - 1)]) begin
        off = IDX_W'(k - 1);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (IDX_W + 1)'(N_REQ)) begin
      sum = sum - (IDX_W + 1)'(N_REQ);
    end
    idx = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/rr_bit_arbiter.sv
// Round-robin arbiter sharing one registered single-bit output between
// N_REQ requesters, with a per-grant hold limit and timeout pulse.
module rr_bit_arbiter
  import rr_arb_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         last,
  input  logic [N_REQ-1:0]         i,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] gnt_id,
  output logic                     busy,
  output logic                     o,
  output logic                     timeout
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);

  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] gnt_id_q, gnt_id_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             o_q, o_d;
  logic             timeout_q, timeout_d;

  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic             cur_req, cur_last, at_limit, release_now;

  rr_prio_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    o_d         = 1'b0;
    timeout_d   = 1'b0;
    cur_req     = req[gnt_id_q];
    cur_last    = last[gnt_id_q];
    at_limit    = (hold_cnt_q == HOLD_LAST);
    release_now = !cur_req || cur_last || at_limit;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d    = GRANT;
          gnt_d      = {{(N_REQ - 1){1'b0}}, 1'b1} << pick_idx;
          gnt_id_d   = pick_idx;
          hold_cnt_d = '0;
        end
      end
      GRANT: begin
        hold_cnt_d = hold_cnt_q + 1'b1;
        o_d        = i[gnt_id_q];
        if (release_now) begin
          state_d    = IDLE;
          gnt_d      = '0;
          o_d        = 1'b0;
          hold_cnt_d = '0;
          ptr_d      = (gnt_id_q == LAST_IDX) ? '0 : gnt_id_q + 1'b1;
          // Only a pure hold-limit expiry counts as a timeout.
          timeout_d  = at_limit && cur_req && !cur_last;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      o_q        <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      o_q        <= o_d;
      timeout_q  <= timeout_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign busy    = (state_q == GRANT);
  assign o       = o_q;
  assign timeout = timeout_q;

`ifndef SYNTHESIS
  rr_pick_t ref_pick;
  assign ref_pick = rr_pick(RR_MAX_REQ'(req), 32'(ptr_q), N_REQ);

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(gnt_q));
      assert (busy == |gnt_q);
      assert (busy || !o_q);
      if (state_q == IDLE) begin
        assert (pick_valid == ref_pick.valid &&
                (!ref_pick.valid || pick_idx == ref_pick.idx[IDX_W-1:0]));
      end
    end
  end
`endif

endmodule

// File: tb/tb_rr_bit_arbiter.sv
// Directed bench for rr_bit_arbiter: a 4-requester/hold-8 instance and a
// 2-requester/hold-1 instance sharing clock and reset.
module tb_rr_bit_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0, last = '0, i = '0;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy, o, timeout;

  logic [1:0] req2 = '0, last2 = '0, i2 = '0;
  logic [1:0] gnt2;
  logic       gnt_id2, busy2, o2, timeout2;

  int unsigned checks = 0;
  int unsigned fails  = 0;

  always #5 clk = ~clk;

  rr_bit_arbiter #(.N_REQ(4), .HOLD_MAX(8)) dut (
    .clk(clk), .rst(rst), .req(req), .last(last), .i(i),
    .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .o(o), .timeout(timeout)
  );

  rr_bit_arbiter #(.N_REQ(2), .HOLD_MAX(1)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .last(last2), .i(i2),
    .gnt(gnt2), .gnt_id(gnt_id2), .busy(busy2), .o(o2), .timeout(timeout2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; last = '0; i = '0; req2 = '0;
    step(); step();
    checks++;
    if ({gnt, gnt_id, busy, o, timeout} !== 9'b0) begin
      fails++;
      $display("FAIL reset_dut {gnt,id,busy,o,to}: got %b want %b", {gnt, gnt_id, busy, o, timeout}, 9'b0);
    end
    checks++;
    if ({gnt2, gnt_id2, busy2, o2, timeout2} !== 6'b0) begin
      fails++;
      $display("FAIL reset_dut2 {gnt,id,busy,o,to}: got %b want %b", {gnt2, gnt_id2, busy2, o2, timeout2}, 6'b0);
    end
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if ({gnt, gnt_id, busy, o, timeout} !== 9'b0) begin
        fails++;
        $display("FAIL idle_quiet cyc %0d: got %b want %b", c, {gnt, gnt_id, busy, o, timeout}, 9'b0);
      end
    end
  endtask

  task automatic test_alternate();
    logic [1:0] id;
    req = 4'b0101;
    for (int g = 0; g < 4; g++) begin
      id = (g % 2 == 0) ? 2'd0 : 2'd2;
      step();
      checks++;
      if ({gnt, gnt_id, busy, o, timeout} !== {4'b0001 << id, id, 3'b100}) begin
        fails++;
        $display("FAIL alt_grant g%0d: got %b want %b", g, {gnt, gnt_id, busy, o, timeout}, {4'b0001 << id, id, 3'b100});
      end
      step();
      checks++;
      if ({busy, timeout} !== 2'b10) begin
        fails++;
        $display("FAIL alt_cyc2 g%0d {busy,to}: got %b want 10", g, {busy, timeout});
      end
      step();
      checks++;
      if ({gnt_id, busy, timeout} !== {id, 2'b10}) begin
        fails++;
        $display("FAIL alt_cyc3 g%0d {id,busy,to}: got %b want %b", g, {gnt_id, busy, timeout}, {id, 2'b10});
      end
      last = 4'b0001 << id;
      step();
      checks++;
      if ({gnt, gnt_id, busy, o, timeout} !== {4'b0000, id, 3'b000}) begin
        fails++;
        $display("FAIL alt_bubble g%0d: got %b want %b", g, {gnt, gnt_id, busy, o, timeout}, {4'b0000, id, 3'b000});
      end
      last = '0;
      if (g == 3) req = '0;
    end
  endtask

  task automatic test_hold_limit();
    logic exp_o;
    req = 4'b0010;
    i   = '0;
    step();
    checks++;
    if ({gnt, gnt_id, busy, o, timeout} !== {4'b0010, 2'd1, 3'b100}) begin
      fails++;
      $display("FAIL hold_grant: got %b want %b", {gnt, gnt_id, busy, o, timeout}, {4'b0010, 2'd1, 3'b100});
    end
    i[1] = 1'b1;
    for (int k = 2; k <= 8; k++) begin
      step();
      exp_o = ((k - 1) % 2) == 1;
      checks++;
      if ({busy, o, timeout} !== {1'b1, exp_o, 1'b0}) begin
        fails++;
        $display("FAIL hold_cyc%0d {busy,o,to}: got %b want %b", k, {busy, o, timeout}, {1'b1, exp_o, 1'b0});
      end
      i[1] = (k % 2) == 1;
    end
    step();
    checks++;
    if ({gnt, gnt_id, busy, o, timeout} !== {4'b0000, 2'd1, 3'b001}) begin
      fails++;
      $display("FAIL hold_timeout: got %b want %b", {gnt, gnt_id, busy, o, timeout}, {4'b0000, 2'd1, 3'b001});
    end
    step();
    checks++;
    if ({gnt, gnt_id, busy, o, timeout} !== {4'b0010, 2'd1, 3'b100}) begin
      fails++;
      $display("FAIL hold_regrant: got %b want %b", {gnt, gnt_id, busy, o, timeout}, {4'b0010, 2'd1, 3'b100});
    end
    req = '0;
    i   = '0;
    step();
    checks++;
    if ({gnt, busy, o, timeout} !== 7'b0) begin
      fails++;
      $display("FAIL hold_drop: got %b want %b", {gnt, busy, o, timeout}, 7'b0);
    end
  endtask

  task automatic test_last_at_limit();
    req = 4'b1111;
    step();
    checks++;
    if ({gnt, gnt_id, busy, timeout} !== {4'b0100, 2'd2, 2'b10}) begin
      fails++;
      $display("FAIL lim_grant: got %b want %b", {gnt, gnt_id, busy, timeout}, {4'b0100, 2'd2, 2'b10});
    end
    for (int k = 2; k <= 8; k++) begin
      step();
      checks++;
      if ({busy, timeout} !== 2'b10) begin
        fails++;
        $display("FAIL lim_cyc%0d {busy,to}: got %b want 10", k, {busy, timeout});
      end
      if (k == 8) last = 4'b0100;
    end
    step();
    checks++;
    if ({gnt, gnt_id, busy, o, timeout} !== {4'b0000, 2'd2, 3'b000}) begin
      fails++;
      $display("FAIL lim_release: got %b want %b", {gnt, gnt_id, busy, o, timeout}, {4'b0000, 2'd2, 3'b000});
    end
    last = '0;
    i    = 4'b1000;
    step();
    checks++;
    if ({gnt, gnt_id, busy, timeout} !== {4'b1000, 2'd3, 2'b10}) begin
      fails++;
      $display("FAIL lim_next: got %b want %b", {gnt, gnt_id, busy, timeout}, {4'b1000, 2'd3, 2'b10});
    end
  endtask

  task automatic test_reset_in_grant();
    step();
    checks++;
    if ({gnt_id, busy, o} !== {2'd3, 2'b11}) begin
      fails++;
      $display("FAIL rst_pre {id,busy,o}: got %b want %b", {gnt_id, busy, o}, {2'd3, 2'b11});
    end
    rst = 1'b1;
    step();
    checks++;
    if ({gnt, gnt_id, busy, o, timeout} !== 9'b0) begin
      fails++;
      $display("FAIL rst_clear: got %b want %b", {gnt, gnt_id, busy, o, timeout}, 9'b0);
    end
    rst = 1'b0;
    req = 4'b1001;
    i   = '0;
    step();
    checks++;
    if ({gnt, gnt_id, busy, o, timeout} !== {4'b0001, 2'd0, 3'b100}) begin
      fails++;
      $display("FAIL rst_ptr0: got %b want %b", {gnt, gnt_id, busy, o, timeout}, {4'b0001, 2'd0, 3'b100});
    end
    req = '0;
    step();
    checks++;
    if ({busy, timeout} !== 2'b00) begin
      fails++;
      $display("FAIL rst_drop {busy,to}: got %b want 00", {busy, timeout});
    end
  endtask

  task automatic test_single_cycle();
    logic id;
    req2 = 2'b11;
    for (int g = 0; g < 4; g++) begin
      id = (g % 2) == 1;
      step();
      checks++;
      if ({gnt2, gnt_id2, busy2, timeout2} !== {2'b01 << id, id, 2'b10}) begin
        fails++;
        $display("FAIL single_grant g%0d: got %b want %b", g, {gnt2, gnt_id2, busy2, timeout2}, {2'b01 << id, id, 2'b10});
      end
      step();
      checks++;
      if ({gnt2, gnt_id2, busy2, o2, timeout2} !== {2'b00, id, 3'b001}) begin
        fails++;
        $display("FAIL single_timeout g%0d: got %b want %b", g, {gnt2, gnt_id2, busy2, o2, timeout2}, {2'b00, id, 3'b001});
      end
    end
    req2 = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_hold_limit();
    test_last_at_limit();
    test_reset_in_grant();
    test_single_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
